// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: op-select bit positions,
// FSM state encoding and the one-hot check used on the op select.
package alu_pkg;

    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_NOT  = 3;
    localparam int OP_ADD  = 4;
    localparam int OP_SUB  = 5;
    localparam int OP_MULT = 6;
    localparam int NUM_OPS = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // True when exactly one select bit is set (popcount == 1).
    function automatic logic is_one_hot(input logic [NUM_OPS-1:0] s);
        int cnt;
        cnt = 0;
        for (int i = 0; i < NUM_OPS; i++) begin
            cnt = cnt + int'(s[i]);
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between operand fetch, the ALU stage and writeback.
// master = upstream/downstream environment, slave = the ALU stage itself.
interface alu_result_stage_if #(parameter int WIDTH = 8);
    import alu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [NUM_OPS-1:0]   sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     res;
    logic [WIDTH-1:0]     res_hi;
    logic                 zero;
    logic                 carry;
    logic                 ovf;
    logic                 err;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, res, res_hi, zero, carry, ovf, err
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, res, res_hi, zero, carry, ovf, err
    );

endinterface

// File: rtl/alu_shift_add_mult.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, LSB first.
// The accumulator holds {partial_high, remaining_multiplier_bits}; each step adds
// the multiplicand to the high half when the current LSB is set, then shifts right.
// done pulses in the cycle the final step is computed and product carries that
// step's result combinationally, so the caller can register it on the same edge.
module alu_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       partial;
    logic [2*WIDTH-1:0]   acc_step;
    logic                 last;

    // One add-shift step of the accumulator and detection of the final iteration.
    always_comb begin
        partial  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = {partial, acc_q[WIDTH-1:1]};
        last     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Next-state: latch operands on start, otherwise iterate while busy.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        if (start) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            mcand_d = a;
            acc_d   = {{WIDTH{1'b0}}, b};
        end else if (busy_q) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    // Iteration state registers; reset abandons any multiply in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

    assign busy    = busy_q;
    assign done    = last;
    assign product = acc_step;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU execute stage. Single-cycle logic/add/sub ops are registered
// straight into the output stage; MULT is handed to the shift-add multiplier
// and its product is registered when it signals done. Results are held until
// the downstream accepts them, and a HOLD with out_ready can take the next op
// in the same cycle.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_result_stage_if.slave alu
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [WIDTH-1:0]     res_hi_q, res_hi_d;
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;

    logic                 legal;
    logic                 is_mult;
    logic                 in_ready;
    logic                 accept;
    logic                 mult_start;
    logic                 mult_busy;
    logic                 mult_done;
    logic [2*WIDTH-1:0]   mult_product;

    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_diff;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry;
    logic                 alu_ovf;

    alu_shift_add_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mult_start),
        .a       (alu.a),
        .b       (alu.b),
        .busy    (mult_busy),
        .done    (mult_done),
        .product (mult_product)
    );

    assign legal    = is_one_hot(alu.sel);
    assign is_mult  = legal && alu.sel[OP_MULT];
    // Held low while reset is asserted; the multiplier is never busy outside MUL.
    assign in_ready = rst_n && !mult_busy &&
                      ((state_q == IDLE) || ((state_q == HOLD) && alu.out_ready));
    assign accept   = alu.in_valid && in_ready;

    // Single-cycle ops; carry is the ADD carry-out or the SUB borrow.
    always_comb begin
        add_sum   = {1'b0, alu.a} + {1'b0, alu.b};
        sub_diff  = {1'b0, alu.a} - {1'b0, alu.b};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        if (legal) begin
            if (alu.sel[OP_AND]) begin
                alu_res = alu.a & alu.b;
            end else if (alu.sel[OP_OR]) begin
                alu_res = alu.a | alu.b;
            end else if (alu.sel[OP_XOR]) begin
                alu_res = alu.a ^ alu.b;
            end else if (alu.sel[OP_NOT]) begin
                alu_res = ~alu.a;
            end else if (alu.sel[OP_ADD]) begin
                alu_res   = add_sum[WIDTH-1:0];
                alu_carry = add_sum[WIDTH];
                alu_ovf   = (alu.a[WIDTH-1] == alu.b[WIDTH-1]) &&
                            (add_sum[WIDTH-1] != alu.a[WIDTH-1]);
            end else if (alu.sel[OP_SUB]) begin
                alu_res   = sub_diff[WIDTH-1:0];
                alu_carry = sub_diff[WIDTH];
                alu_ovf   = (alu.a[WIDTH-1] != alu.b[WIDTH-1]) &&
                            (sub_diff[WIDTH-1] != alu.a[WIDTH-1]);
            end
        end
    end

    // FSM next-state and output-register load decisions.
    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        res_hi_d   = res_hi_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        mult_start = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    if (is_mult) begin
                        state_d    = MUL;
                        mult_start = 1'b1;
                    end else begin
                        // Illegal selects land here too: alu_res is 0, so zero=1.
                        state_d  = HOLD;
                        res_d    = alu_res;
                        res_hi_d = '0;
                        zero_d   = (alu_res == '0);
                        carry_d  = alu_carry;
                        ovf_d    = alu_ovf;
                        err_d    = !legal;
                    end
                end else if ((state_q == HOLD) && alu.out_ready) begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (mult_done) begin
                    state_d  = HOLD;
                    res_d    = mult_product[WIDTH-1:0];
                    res_hi_d = mult_product[2*WIDTH-1:WIDTH];
                    zero_d   = (mult_product == '0);
                    carry_d  = 1'b0;
                    ovf_d    = (mult_product[2*WIDTH-1:WIDTH] != '0);
                    err_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            res_q    <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign alu.in_ready  = in_ready;
    assign alu.out_valid = (state_q == HOLD);
    assign alu.res       = res_q;
    assign alu.res_hi    = res_hi_q;
    assign alu.zero      = zero_q;
    assign alu.carry     = carry_q;
    assign alu.ovf       = ovf_q;
    assign alu.err       = err_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (WIDTH=8) with a scoreboard of expected results.
module tb_alu_result_stage;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] res_hi;
        logic         zero;
        logic         carry;
        logic         ovf;
        logic         err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_mis;
    exp_t sb[$];

    alu_result_stage_if #(.WIDTH(W)) alu_bus ();

    alu_result_stage #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .alu   (alu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour written from the operation definitions using integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [6:0] sel);
        exp_t e;
        int   s;
        int   ss;
        int   p;
        e  = '0;
        s  = 0;
        ss = 0;
        p  = 0;
        if ($countones(sel) != 1) begin
            e.err  = 1'b1;
            e.zero = 1'b1;
            return e;
        end
        if (sel[0]) e.res = a & b;
        if (sel[1]) e.res = a | b;
        if (sel[2]) e.res = a ^ b;
        if (sel[3]) e.res = ~a;
        if (sel[4]) begin
            s       = int'(a) + int'(b);
            ss      = int'($signed(a)) + int'($signed(b));
            e.res   = s[7:0];
            e.carry = (s > 255);
            e.ovf   = (ss > 127) || (ss < -128);
        end
        if (sel[5]) begin
            s       = int'(a) - int'(b);
            ss      = int'($signed(a)) - int'($signed(b));
            e.res   = s[7:0];
            e.carry = (a < b);
            e.ovf   = (ss > 127) || (ss < -128);
        end
        if (sel[6]) begin
            p        = int'(a) * int'(b);
            e.res    = p[7:0];
            e.res_hi = p[15:8];
            e.ovf    = (p > 255);
        end
        e.zero = ({e.res_hi, e.res} == 16'h0000);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, "/out_valid"}, 32'(alu_bus.out_valid), 32'(1));
        check({tag, "/res"},       32'(alu_bus.res),       32'(e.res));
        check({tag, "/res_hi"},    32'(alu_bus.res_hi),    32'(e.res_hi));
        check({tag, "/zero"},      32'(alu_bus.zero),      32'(e.zero));
        check({tag, "/carry"},     32'(alu_bus.carry),     32'(e.carry));
        check({tag, "/ovf"},       32'(alu_bus.ovf),       32'(e.ovf));
        check({tag, "/err"},       32'(alu_bus.err),       32'(e.err));
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "/scoreboard_empty"}, 32'(0), 32'(1));
        end else begin
            e = sb.pop_front();
            check_outputs(tag, e);
        end
        $display("op %s: a=%02h b=%02h sel=%07b -> res=%02h res_hi=%02h z=%0b c=%0b v=%0b e=%0b",
                 tag, alu_bus.a, alu_bus.b, alu_bus.sel, alu_bus.res, alu_bus.res_hi,
                 alu_bus.zero, alu_bus.carry, alu_bus.ovf, alu_bus.err);
    endtask

    // Called at a negedge with out_ready=1; returns at the negedge where the result was checked.
    task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [6:0] sel, input string tag, input int exp_lat);
        int w;
        int lat;
        int stall;
        alu_bus.a        = a;
        alu_bus.b        = b;
        alu_bus.sel      = sel;
        alu_bus.in_valid = 1'b1;
        w = 0;
        while (!alu_bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "/in_ready"}, 32'(alu_bus.in_ready), 32'(1));
        sb.push_back(model(a, b, sel));
        @(posedge clk);
        @(negedge clk);
        alu_bus.in_valid = 1'b0;
        alu_bus.a        = ~a;
        alu_bus.b        = ~b;
        lat   = 1;
        stall = 0;
        while (!alu_bus.out_valid && lat < 50) begin
            if (!alu_bus.in_ready) stall++;
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/in_ready_low_cycles"}, 32'(stall), 32'(exp_lat - 1));
        pop_compare(tag);
    endtask

    initial begin
        logic [6:0] rsel;
        logic [6:0] hsel;
        int         op;
        int         seen;
        n_vec = 0;
        n_mis = 0;
        rst_n             = 1'b0;
        alu_bus.in_valid  = 1'b0;
        alu_bus.a         = '0;
        alu_bus.b         = '0;
        alu_bus.sel       = '0;
        alu_bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset/in_ready",  32'(alu_bus.in_ready),  32'(0));
        check("reset/out_valid", 32'(alu_bus.out_valid), 32'(0));
        check("reset/res",       32'(alu_bus.res),       32'(0));
        check("reset/res_hi",    32'(alu_bus.res_hi),    32'(0));
        check("reset/zero",      32'(alu_bus.zero),      32'(0));
        check("reset/carry",     32'(alu_bus.carry),     32'(0));
        check("reset/ovf",       32'(alu_bus.ovf),       32'(0));
        check("reset/err",       32'(alu_bus.err),       32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset/in_ready",  32'(alu_bus.in_ready),  32'(1));
        check("post_reset/out_valid", 32'(alu_bus.out_valid), 32'(0));

        // Directed single operations
        send_op(8'hFF, 8'h01, 7'b0010000, "add_ff_01", 1);
        send_op(8'h80, 8'h01, 7'b0100000, "sub_80_01", 1);
        send_op(8'h01, 8'h02, 7'b0100000, "sub_01_02", 1);
        send_op(8'h0F, 8'h11, 7'b1000000, "mul_0f_11", 9);
        send_op(8'hFF, 8'hFF, 7'b1000000, "mul_ff_ff", 9);
        send_op(8'h5A, 8'h3C, 7'b0000011, "illegal_2bit", 1);
        send_op(8'h5A, 8'h3C, 7'b0000000, "illegal_zero", 1);
        send_op(8'h5A, 8'h3C, 7'b0000001, "and_after_err", 1);
        send_op(8'h5A, 8'h3C, 7'b0000010, "or", 1);
        send_op(8'hA5, 8'hFF, 7'b0001000, "not", 1);
        send_op(8'h7F, 8'h01, 7'b0010000, "add_7f_01", 1);
        send_op(8'h00, 8'h37, 7'b1000000, "mul_zero", 9);

        // Backpressure: result held with out_ready low; new input ignored meanwhile
        @(negedge clk);
        alu_bus.out_ready = 1'b0;
        alu_bus.a         = 8'h12;
        alu_bus.b         = 8'h34;
        alu_bus.sel       = 7'b0010000;
        alu_bus.in_valid  = 1'b1;
        sb.push_back(model(8'h12, 8'h34, 7'b0010000));
        @(posedge clk);
        @(negedge clk);
        alu_bus.a   = 8'hEE;
        alu_bus.b   = 8'h11;
        hsel        = 7'b0000100;
        alu_bus.sel = hsel;
        for (int k = 0; k < 4; k++) begin
            check("hold/in_ready", 32'(alu_bus.in_ready), 32'(0));
            check("hold/res", 32'(alu_bus.res), 32'(sb[0].res));
            check("hold/out_valid", 32'(alu_bus.out_valid), 32'(1));
            $display("hold cycle %0d: out_valid=%0b res=%02h in_ready=%0b",
                     k, alu_bus.out_valid, alu_bus.res, alu_bus.in_ready);
            if (k < 3) @(negedge clk);
        end
        alu_bus.in_valid  = 1'b0;
        alu_bus.out_ready = 1'b1;
        pop_compare("hold_release");
        @(negedge clk);
        check("hold/drained_out_valid", 32'(alu_bus.out_valid), 32'(0));

        // Back-to-back XOR with out_ready high: one result per cycle
        alu_bus.a        = 8'h01;
        alu_bus.b        = 8'hF0;
        alu_bus.sel      = 7'b0000100;
        alu_bus.in_valid = 1'b1;
        sb.push_back(model(8'h01, 8'hF0, 7'b0000100));
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("b2b/in_ready", 32'(alu_bus.in_ready), 32'(1));
            pop_compare("xor_b2b");
            if (i < 4) begin
                alu_bus.a = 8'(i * 37);
                alu_bus.b = 8'(8'hC3 ^ 8'(i));
                sb.push_back(model(alu_bus.a, alu_bus.b, 7'b0000100));
            end else begin
                alu_bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);

        // Reset during multiply: pending product discarded
        alu_bus.a        = 8'hFF;
        alu_bus.b        = 8'hFF;
        alu_bus.sel      = 7'b1000000;
        alu_bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        alu_bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midmul_reset/in_ready",  32'(alu_bus.in_ready),  32'(0));
        check("midmul_reset/out_valid", 32'(alu_bus.out_valid), 32'(0));
        check("midmul_reset/res",       32'(alu_bus.res),       32'(0));
        check("midmul_reset/res_hi",    32'(alu_bus.res_hi),    32'(0));
        check("midmul_reset/zero",      32'(alu_bus.zero),      32'(0));
        check("midmul_reset/carry",     32'(alu_bus.carry),     32'(0));
        check("midmul_reset/ovf",       32'(alu_bus.ovf),       32'(0));
        check("midmul_reset/err",       32'(alu_bus.err),       32'(0));
        $display("reset during MULT: out_valid=%0b res=%02h res_hi=%02h",
                 alu_bus.out_valid, alu_bus.res, alu_bus.res_hi);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (alu_bus.out_valid) seen++;
        end
        check("midmul_reset/no_stale_result", 32'(seen), 32'(0));
        send_op(8'h21, 8'h43, 7'b0010000, "add_after_reset", 1);

        // Random legal ops
        for (int i = 0; i < 8; i++) begin
            op   = int'($urandom_range(0, 6));
            rsel = 7'(1) << op;
            send_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rsel,
                    "random", (op == 6) ? 9 : 1);
        end

        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
